main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm.sv | 132 +++++++++++++
 tb/tb_main_fsm.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle control FSM: sequences fetch, decode, memory, ALU and branch steps.
// Outputs are decoded from the state register plus the few handshake/decode inputs that qualify them.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e state_q, state_d;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      // Unused codes 10-15 recover to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 1'b0;
    pcs        = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // Reset masks the load so a ready memory cannot latch an instruction mid-reset.
        ir_write   = mem_ready & reset;
        pcs        = mem_ready & reset;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        illegal    = (op == 2'b11);
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: alu_op = 1'b1;
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: each driven cycle pushes its expected output vector,
// a monitor pops and compares it once the outputs have settled.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       ir_write, adr_src, alu_src_a, alu_op, pcs, reg_w, mem_w, branch, instr_done, illegal;
  logic [1:0] alu_src_b, result_src;
  logic [3:0] state;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc_no       = 0;

  logic [17:0] exp_q[$];

  // Expected output vectors, one per state flavour.
  logic [17:0] e_fetch_w, e_fetch_r, e_dec, e_dec_ill, e_memadr, e_memread, e_memwb;
  logic [17:0] e_memwr_w, e_memwr_r, e_execr, e_execi, e_aluwb, e_branch;

  main_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .pcs        (pcs),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .branch     (branch),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input logic ir, input logic adr, input logic a,
                                     input logic [1:0] b, input logic [1:0] res, input logic aop,
                                     input logic pc, input logic rw, input logic mw, input logic br,
                                     input logic dn, input logic il, input logic [3:0] st);
    return {ir, adr, a, b, res, aop, pc, rw, mw, br, dn, il, st};
  endfunction

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and record what the outputs must be.
  task automatic cyc(input logic rst, input logic mr, input logic [1:0] o, input logic [5:0] f,
                     input logic [17:0] e);
    @(negedge clk);
    reset     = rst;
    mem_ready = mr;
    op        = o;
    funct     = f;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [17:0] got, want;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_op, pcs,
                reg_w, mem_w, branch, instr_done, illegal, state};
        check($sformatf("cycle%0d_outputs", cyc_no), {14'd0, got}, {14'd0, want});
      end
      cyc_no++;
    end
  end

  initial begin
    //                ir adr a  b     res   aop pcs rw mw br dn il st
    e_fetch_w = pk(0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    e_fetch_r = pk(1, 0, 1, 2'b10, 2'b10, 0, 1, 0, 0, 0, 0, 0, 4'd0);
    e_dec     = pk(0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'd1);
    e_dec_ill = pk(0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 1, 4'd1);
    e_memadr  = pk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd2);
    e_memread = pk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd3);
    e_memwb   = pk(0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 0, 0, 1, 0, 4'd4);
    e_memwr_w = pk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 4'd5);
    e_memwr_r = pk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 4'd5);
    e_execr   = pk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'd6);
    e_execi   = pk(0, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'd7);
    e_aluwb   = pk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 1, 0, 4'd8);
    e_branch  = pk(0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 0, 1, 1, 0, 4'd9);

    reset = 1'b0; mem_ready = 1'b0; op = 2'b00; funct = 6'd0;

    // Held in reset with a ready memory: FETCH selects only, no load.
    cyc(0, 1, 2'b00, 6'b000000, e_fetch_w);
    cyc(0, 1, 2'b00, 6'b000000, e_fetch_w);

    // Release with memory not ready: FETCH holds.
    cyc(1, 0, 2'b00, 6'b001000, e_fetch_w);

    // ADD register; junk op/funct outside DECODE/MEMADR must be ignored.
    cyc(1, 1, 2'b11, 6'b111111, e_fetch_r);
    cyc(1, 1, 2'b00, 6'b001000, e_dec);
    cyc(1, 1, 2'b11, 6'b100001, e_execr);
    cyc(1, 1, 2'b10, 6'b100001, e_aluwb);

    // Data-processing immediate.
    cyc(1, 1, 2'b00, 6'b100000, e_fetch_r);
    cyc(1, 1, 2'b00, 6'b100000, e_dec);
    cyc(1, 1, 2'b01, 6'b000000, e_execi);
    cyc(1, 1, 2'b01, 6'b000000, e_aluwb);

    // LDR with two wait cycles in MEMREAD.
    cyc(1, 1, 2'b01, 6'b011001, e_fetch_r);
    cyc(1, 1, 2'b01, 6'b011001, e_dec);
    cyc(1, 1, 2'b01, 6'b011001, e_memadr);
    cyc(1, 0, 2'b00, 6'b000000, e_memread);
    cyc(1, 0, 2'b00, 6'b000000, e_memread);
    cyc(1, 1, 2'b00, 6'b000000, e_memread);
    cyc(1, 1, 2'b00, 6'b000000, e_memwb);

    // STR, memory ready.
    cyc(1, 1, 2'b01, 6'b011000, e_fetch_r);
    cyc(1, 1, 2'b01, 6'b011000, e_dec);
    cyc(1, 1, 2'b01, 6'b011000, e_memadr);
    cyc(1, 1, 2'b01, 6'b011001, e_memwr_r);

    // STR with one wait cycle; mem_w stays high while waiting.
    cyc(1, 1, 2'b01, 6'b000000, e_fetch_r);
    cyc(1, 1, 2'b01, 6'b000000, e_dec);
    cyc(1, 1, 2'b01, 6'b000000, e_memadr);
    cyc(1, 0, 2'b01, 6'b000000, e_memwr_w);
    cyc(1, 1, 2'b01, 6'b000000, e_memwr_r);

    // Branch.
    cyc(1, 1, 2'b10, 6'b000000, e_fetch_r);
    cyc(1, 1, 2'b10, 6'b000000, e_dec);
    cyc(1, 1, 2'b00, 6'b000000, e_branch);

    // Illegal op: back to FETCH after DECODE.
    cyc(1, 1, 2'b11, 6'b000000, e_fetch_r);
    cyc(1, 1, 2'b11, 6'b000000, e_dec_ill);
    cyc(1, 0, 2'b11, 6'b000000, e_fetch_w);

    // Asynchronous reset in the middle of a store wait.
    cyc(1, 1, 2'b01, 6'b011000, e_fetch_r);
    cyc(1, 1, 2'b01, 6'b011000, e_dec);
    cyc(1, 1, 2'b01, 6'b011000, e_memadr);
    cyc(1, 0, 2'b01, 6'b011000, e_memwr_w);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_state", {28'd0, state}, 32'd0);
    check("async_reset_mem_w", {31'd0, mem_w}, 32'd0);
    cyc(0, 1, 2'b01, 6'b011000, e_fetch_w);
    cyc(1, 0, 2'b01, 6'b011000, e_fetch_w);
    cyc(1, 0, 2'b01, 6'b011000, e_fetch_w);
    cyc(1, 1, 2'b00, 6'b000000, e_fetch_r);
    cyc(1, 1, 2'b00, 6'b000000, e_dec);
    cyc(1, 1, 2'b00, 6'b000000, e_execr);
    cyc(1, 1, 2'b00, 6'b000000, e_aluwb);
    cyc(1, 0, 2'b00, 6'b000000, e_fetch_w);

    @(negedge clk);
    #5;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
